// File: rtl/video_pkg.sv
// Shared types for the video fade path.
// Rate width and fade FSM state encoding.
package video_pkg;

  localparam int RATE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/video_fade_step.sv
// Saturating rate stepper: moves rate toward target by step.
// Never overshoots; lands exactly on target.
module video_fade_step
  import video_pkg::*;
(
  input  logic [RATE_W-1:0] rate_i,
  input  logic [RATE_W-1:0] target_i,
  input  logic [RATE_W-1:0] step_i,
  input  logic              dir_i,
  output logic [RATE_W-1:0] next_rate_o,
  output logic              hit_o
);

  logic [RATE_W:0] diff;

  always_comb begin
    if (dir_i)
      diff = {1'b0, target_i} - {1'b0, rate_i};
    else
      diff = {1'b0, rate_i} - {1'b0, target_i};
    if (diff <= {1'b0, step_i})
      next_rate_o = target_i;
    else if (dir_i)
      next_rate_o = rate_i + step_i;
    else
      next_rate_o = rate_i - step_i;
    hit_o = (next_rate_o == target_i);
  end

endmodule

// File: rtl/video_fade_ctl.sv
// Frame-synchronous alpha ramp controller.
// Steps the mixer blend rate toward a target only on vsync.
module video_fade_ctl
  import video_pkg::*;
#(
  parameter int FDIV_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync_pulse,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [RATE_W-1:0] cmd_target,
  input  logic [RATE_W-1:0] cmd_step,
  input  logic [FDIV_W-1:0] cmd_frames,
  input  logic              abort,
  output logic [RATE_W-1:0] rate,
  output logic              busy,
  output logic              done
);

  state_e state_q, state_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [RATE_W-1:0] tgt_q, tgt_d;
  logic [RATE_W-1:0] step_q, step_d;
  logic [FDIV_W-1:0] frm_q, frm_d;
  logic [FDIV_W-1:0] cnt_q, cnt_d;
  logic              up_q, up_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              tick;
  logic [RATE_W-1:0] nxt_rate;
  logic              hit;

  video_fade_step u_step (
    .rate_i      (rate_q),
    .target_i    (tgt_q),
    .step_i      (step_q),
    .dir_i       (up_q),
    .next_rate_o (nxt_rate),
    .hit_o       (hit)
  );

  // abort masks the handshake so a coincident command is refused
  assign cmd_ready = (state_q == IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (cnt_q == FDIV_W'(1));

  assign rate = rate_q;
  assign busy = busy_q;
  assign done = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rate_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      frm_q   <= '0;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      frm_q   <= frm_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && (cmd_target != rate_q))
          state_d = ARMED;
      end
      ARMED: begin
        if (abort)
          state_d = IDLE;
        else if (vsync_pulse)
          state_d = RUN;
      end
      RUN: begin
        if (abort)
          state_d = IDLE;
        else if (vsync_pulse && tick && hit)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rate_d = rate_q;
    tgt_d  = tgt_q;
    step_d = step_q;
    frm_d  = frm_q;
    cnt_d  = cnt_q;
    up_d   = up_q;
    busy_d = busy_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d  = cmd_target;
          step_d = (cmd_step == '0) ? RATE_W'(1) : cmd_step;
          frm_d  = (cmd_frames == '0) ? FDIV_W'(1) : cmd_frames;
          up_d   = (cmd_target > rate_q);
          if (cmd_target == rate_q)
            done_d = 1'b1;
          else
            busy_d = 1'b1;
        end
      end
      ARMED: begin
        if (abort)
          busy_d = 1'b0;
        else if (vsync_pulse)
          cnt_d = frm_q;
      end
      RUN: begin
        if (abort) begin
          busy_d = 1'b0;
        end else if (vsync_pulse) begin
          if (tick) begin
            cnt_d  = frm_q;
            rate_d = nxt_rate;
            if (hit) begin
              done_d = 1'b1;
              busy_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - FDIV_W'(1);
          end
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_video_fade_ctl.sv
// Scoreboard bench for video_fade_ctl.
// Expected rate events come from an arithmetic fade model.
module tb_video_fade_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync_pulse;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_target;
  logic [7:0] cmd_step;
  logic [7:0] cmd_frames;
  logic       abort;
  logic [7:0] rate;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  video_fade_ctl #(.FDIV_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .vsync_pulse (vsync_pulse),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .cmd_step    (cmd_step),
    .cmd_frames  (cmd_frames),
    .abort       (abort),
    .rate        (rate),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int rate;
    bit done;
    int vidx;
  } ev_t;

  ev_t        exq[$];
  ev_t        mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         vs_cnt = 0;
  int         ncyc = 0;
  int         acc_cyc = 0;
  int         model_rate = 0;
  logic [7:0] prev_rate = 8'h00;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // model: list every rate the fade visits and the vsync it lands on
  task automatic push_fade(int t, int s, int f);
    int r, ss, ff, k;
    ev_t e;
    r  = model_rate;
    ss = (s == 0) ? 1 : s;
    ff = (f == 0) ? 1 : f;
    if (t == r) begin
      e.rate = r; e.done = 1'b1; e.vidx = -1;
      exq.push_back(e);
    end else begin
      k = 0;
      while (r != t) begin
        k++;
        if (t > r) r = (t - r <= ss) ? t : r + ss;
        else       r = (r - t <= ss) ? t : r - ss;
        e.rate = r; e.done = (r == t); e.vidx = 1 + k * ff;
        exq.push_back(e);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    ncyc++;
    if (reset) begin
      prev_rate = rate;
    end else if (rate !== prev_rate || done) begin
      if (exq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event rate=%0h done=%0b required=no change",
                 rate, done);
      end else begin
        mon_e = exq.pop_front();
        chk("rate", rate, mon_e.rate);
        chk("done", done, mon_e.done);
        chk("busy_evt", busy, !mon_e.done);
        if (mon_e.vidx < 0) chk("zero_delta_lat", ncyc - acc_cyc, 1);
        else chk("step_vsync_idx", vs_cnt, mon_e.vidx);
        model_rate = mon_e.rate;
      end
      if (rate !== prev_rate) chk("change_after_vsync", vsync_pulse, 1);
      prev_rate = rate;
    end
  end

  task automatic cyc(bit vs, bit ab);
    @(negedge clk);
    vsync_pulse = vs;
    abort = ab;
    if (vs) vs_cnt++;
  endtask

  task automatic frame(int gap, bit ab);
    repeat (gap) cyc(1'b0, 1'b0);
    cyc(1'b1, ab);
  endtask

  task automatic do_cmd(int t, int s, int f, bit vs_acc);
    int r0;
    r0 = model_rate;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_target = 8'(t);
    cmd_step = 8'(s);
    cmd_frames = 8'(f);
    vsync_pulse = vs_acc;
    abort = 1'b0;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    push_fade(t, s, f);
    vs_cnt = 0;
    acc_cyc = ncyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    vsync_pulse = 1'b0;
    #1 chk("busy_after_accept", busy, int'(t != r0));
  endtask

  task automatic wait_fade(int abort_at);
    int n;
    bit ab;
    n = 0;
    while (exq.size() != 0 && n < 2000) begin
      ab = (abort_at != 0) && (vs_cnt + 1 == abort_at);
      frame($urandom_range(0, 3), ab);
      n++;
      if (ab) begin
        cyc(1'b0, 1'b0);
        exq.delete();
        #1;
        chk("busy_after_abort", busy, 0);
        chk("ready_after_abort", cmd_ready, 1);
        chk("rate_hold_abort", rate, model_rate);
        break;
      end
    end
    if (exq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fade_timeout pending=%0d required=0", exq.size());
      exq.delete();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_h;
    reset = 1'b1;
    vsync_pulse = 1'b0;
    cmd_valid = 1'b0;
    cmd_target = 8'h00;
    cmd_step = 8'h00;
    cmd_frames = 8'h00;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rate", rate, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    repeat (3) frame(2, 1'b0);
    #1;
    chk("idle_rate", rate, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", cmd_ready, 1);

    do_cmd('hFF, 'h40, 1, 1'b0);
    wait_fade(0);
    do_cmd('h10, 'h30, 2, 1'b0);
    wait_fade(0);
    do_cmd('h00, 0, 0, 1'b0);
    wait_fade(0);

    do_cmd('h80, 'h20, 1, 1'b0);
    wait_fade(3);
    chk("abort_rate", rate, 'h20);

    @(negedge clk);
    abort = 1'b1;
    #1 chk("ready_during_abort", cmd_ready, 0);
    @(negedge clk);
    abort = 1'b0;
    #1 chk("ready_after_idle_abort", cmd_ready, 1);
    @(negedge clk);
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_target = 8'h99;
    #1 chk("ready_abort_cmd", cmd_ready, 0);
    @(negedge clk);
    abort = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("busy_abort_cmd", busy, 0);
    chk("rate_abort_cmd", rate, 'h20);

    do_cmd('h55, 'h35, 1, 1'b1);
    wait_fade(0);
    do_cmd('h55, 0, 0, 1'b0);
    wait_fade(0);
    chk("zero_delta_rate", rate, 'h55);

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_target = 8'h90;
    cmd_step = 8'h10;
    cmd_frames = 8'd1;
    vsync_pulse = 1'b0;
    abort = 1'b0;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    push_fade('h90, 'h10, 1);
    vs_cnt = 0;
    acc_cyc = ncyc;
    done_h = 1'b0;
    for (int k = 0; k < 500; k++) begin
      cyc(k % 3 == 2, 1'b0);
      cmd_target = 8'h00;
      cmd_step = 8'hFF;
      cmd_frames = 8'd3;
      #1;
      chk("cmd_ready_held", cmd_ready, int'(exq.size() == 0));
      chk("busy_held", busy, int'(exq.size() != 0));
      if (exq.size() == 0) begin
        push_fade('h00, 'hFF, 3);
        vs_cnt = 0;
        acc_cyc = ncyc;
        done_h = 1'b1;
        break;
      end
    end
    if (!done_h) begin
      n_cmp++;
      n_bad++;
      $display("FAIL held_cmd_timeout actual=not accepted required=accepted");
      exq.delete();
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    vsync_pulse = 1'b0;
    wait_fade(0);

    for (int i = 0; i < 25; i++) begin
      int t, s, f, ab;
      t = ($urandom_range(0, 7) == 0) ? model_rate : $urandom_range(0, 255);
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4)
                                      : $urandom_range(0, 255);
      f = $urandom_range(0, 3);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
      do_cmd(t, s, f, 1'($urandom_range(0, 1)));
      wait_fade(ab);
      repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0);
    end

    do_cmd(model_rate ^ 'h80, 1, 1, 1'b0);
    repeat (3) frame(1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    vsync_pulse = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exq.delete();
    model_rate = 0;
    #1;
    chk("midreset_rate", rate, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_ready", cmd_ready, 1);
    repeat (2) frame(1, 1'b0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
